// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register chain with per-stage valid, stall, flush and forwarding lookup.
// Optional bubble counter port enabled by defining MEM_WB_BUBBLE_CNT_EN.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8,
    parameter int RG_W   = 4,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              sel_dat_in,
    input  logic              sel_c_in,
    input  logic              we_v_in,
    input  logic              we_c_in,
    input  logic              sel_sto_in,
    input  logic [DATA_W-1:0] do_in,
    input  logic [BYTE_W-1:0] dob_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [RG_W-1:0]   rg_in,
    input  logic [RG_W-1:0]   q_rg_a,
    input  logic [RG_W-1:0]   q_rg_b,
    output logic              valid,
    output logic              sel_dat,
    output logic              sel_c,
    output logic              we_v,
    output logic              we_c,
    output logic              sel_sto,
    output logic [DATA_W-1:0] do_out,
    output logic [BYTE_W-1:0] dob,
    output logic [DATA_W-1:0] alu_result,
    output logic [RG_W-1:0]   rg,
    output logic              q_hit_a,
    output logic              q_hit_b,
    output logic [DATA_W-1:0] q_data_a,
    output logic [DATA_W-1:0] q_data_b
`ifdef MEM_WB_BUBBLE_CNT_EN
    ,
    output logic [15:0]       bubble_cnt
`endif
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("mem_wb_pipe: DEPTH must be in 1..4");
    end

    typedef struct packed {
        logic              valid;
        logic              sel_dat;
        logic              sel_c;
        logic              we_v;
        logic              we_c;
        logic              sel_sto;
        logic [DATA_W-1:0] dout;
        logic [BYTE_W-1:0] dob;
        logic [DATA_W-1:0] alu;
        logic [RG_W-1:0]   rg;
    } stage_t;

    stage_t in_st;
    stage_t st  [DEPTH];
    stage_t src [DEPTH];

    // Write enables are gated by valid so a bubble can never write back.
    always_comb begin
        in_st         = '0;
        in_st.valid   = valid_in;
        in_st.sel_dat = sel_dat_in;
        in_st.sel_c   = sel_c_in;
        in_st.we_v    = we_v_in & valid_in;
        in_st.we_c    = we_c_in & valid_in;
        in_st.sel_sto = sel_sto_in;
        in_st.dout    = do_in;
        in_st.dob     = dob_in;
        in_st.alu     = alu_result_in;
        in_st.rg      = rg_in;
    end

    always_comb begin
        src[0] = in_st;
        for (int k = 1; k < DEPTH; k++) src[k] = st[k-1];
    end

    // Flush kills control only; payload and rg stay put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) st[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                st[k].valid   <= 1'b0;
                st[k].sel_dat <= 1'b0;
                st[k].sel_c   <= 1'b0;
                st[k].we_v    <= 1'b0;
                st[k].we_c    <= 1'b0;
                st[k].sel_sto <= 1'b0;
            end
        end else if (en) begin
            for (int k = 0; k < DEPTH; k++) st[k] <= src[k];
        end
    end

    assign valid      = st[DEPTH-1].valid;
    assign sel_dat    = st[DEPTH-1].sel_dat;
    assign sel_c      = st[DEPTH-1].sel_c;
    assign we_v       = st[DEPTH-1].we_v;
    assign we_c       = st[DEPTH-1].we_c;
    assign sel_sto    = st[DEPTH-1].sel_sto;
    assign do_out     = st[DEPTH-1].dout;
    assign dob        = st[DEPTH-1].dob;
    assign alu_result = st[DEPTH-1].alu;
    assign rg         = st[DEPTH-1].rg;

    // Scan oldest to youngest so the youngest matching stage overwrites.
    always_comb begin
        q_hit_a  = 1'b0;
        q_hit_b  = 1'b0;
        q_data_a = '0;
        q_data_b = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (st[k].valid && st[k].we_v && st[k].rg == q_rg_a) begin
                q_hit_a  = 1'b1;
                q_data_a = st[k].sel_dat ? st[k].dout : st[k].alu;
            end
            if (st[k].valid && st[k].we_v && st[k].rg == q_rg_b) begin
                q_hit_b  = 1'b1;
                q_data_b = st[k].sel_dat ? st[k].dout : st[k].alu;
            end
        end
    end

`ifdef MEM_WB_BUBBLE_CNT_EN
    // src[DEPTH-1] is what the output stage is about to load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_cnt <= '0;
        else if (en && !flush && !src[DEPTH-1].valid && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe; three instances at DEPTH 1, 2 and 3 share one stimulus.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0, flush = 1'b0, valid_in = 1'b0;
    logic        sel_dat_in = 1'b0, sel_c_in = 1'b0, we_v_in = 1'b0, we_c_in = 1'b0, sel_sto_in = 1'b0;
    logic [31:0] do_in = '0, alu_in = '0;
    logic [7:0]  dob_in = '0;
    logic [3:0]  rg_in = '0, q_rg_a = '0, q_rg_b = '0;

    logic        v [3], sd [3], sc [3], wv [3], wc [3], ss [3], hita [3], hitb [3];
    logic [31:0] dout [3], alu [3], qda [3], qdb [3];
    logic [7:0]  dob [3];
    logic [3:0]  rg [3];
    logic [15:0] bc [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        mem_wb_pipe #(.DEPTH(i + 1)) u (
            .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .valid_in(valid_in),
            .sel_dat_in(sel_dat_in), .sel_c_in(sel_c_in), .we_v_in(we_v_in),
            .we_c_in(we_c_in), .sel_sto_in(sel_sto_in), .do_in(do_in), .dob_in(dob_in),
            .alu_result_in(alu_in), .rg_in(rg_in), .q_rg_a(q_rg_a), .q_rg_b(q_rg_b),
            .valid(v[i]), .sel_dat(sd[i]), .sel_c(sc[i]), .we_v(wv[i]), .we_c(wc[i]),
            .sel_sto(ss[i]), .do_out(dout[i]), .dob(dob[i]), .alu_result(alu[i]), .rg(rg[i]),
            .q_hit_a(hita[i]), .q_hit_b(hitb[i]), .q_data_a(qda[i]), .q_data_b(qdb[i])
`ifdef MEM_WB_BUBBLE_CNT_EN
            , .bubble_cnt(bc[i])
`endif
        );
`ifndef MEM_WB_BUBBLE_CNT_EN
        assign bc[i] = '0;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        en = 1'b0; flush = 1'b0; valid_in = 1'b0;
        sel_dat_in = 1'b0; sel_c_in = 1'b0; we_v_in = 1'b0; we_c_in = 1'b0; sel_sto_in = 1'b0;
        do_in = '0; dob_in = '0; alu_in = '0; rg_in = '0;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state, asserted between edges.
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, v[2]}, 32'd0);
        check("rst_alu", alu[2], 32'd0);
        check("rst_rg", {28'd0, rg[2]}, 32'd0);
        check("rst_hit", {31'd0, hita[2]}, 32'd0);
        tick();
        rst_n = 1'b1;

        // DEPTH=1 single load, rg registered.
        en = 1'b1; valid_in = 1'b1; we_v_in = 1'b1; alu_in = 32'h0000_00A5; rg_in = 4'd3;
        tick();
        check("d1_valid", {31'd0, v[0]}, 32'd1);
        check("d1_we_v", {31'd0, wv[0]}, 32'd1);
        check("d1_alu", alu[0], 32'hA5);
        check("d1_rg", {28'd0, rg[0]}, 32'd3);
        rg_in = 4'd7;
        #2;
        check("d1_rg_hold", {28'd0, rg[0]}, 32'd3);

        // DEPTH=3 stream with a two-cycle stall.
        do_reset();
        en = 1'b1; valid_in = 1'b1;
        alu_in = 32'd1; tick();
        alu_in = 32'd2; tick();
        check("d3_lat_v", {31'd0, v[2]}, 32'd0);
        alu_in = 32'd3; tick();
        check("d3_out1", alu[2], 32'd1);
        check("d3_out1_v", {31'd0, v[2]}, 32'd1);
        en = 1'b0; valid_in = 1'b0;
        tick();
        check("d3_stall1", alu[2], 32'd1);
        tick();
        check("d3_stall2", alu[2], 32'd1);
        en = 1'b1;
        tick();
        check("d3_out2", alu[2], 32'd2);
        tick();
        check("d3_out3", alu[2], 32'd3);
        check("d3_out3_v", {31'd0, v[2]}, 32'd1);
        tick();
        check("d3_drain_v", {31'd0, v[2]}, 32'd0);

        // Flush under stall with three valid stages.
        do_reset();
        en = 1'b1; valid_in = 1'b1; we_v_in = 1'b1; we_c_in = 1'b1; rg_in = 4'd9;
        alu_in = 32'd4; tick();
        alu_in = 32'd5; tick();
        alu_in = 32'd6; tick();
        q_rg_a = 4'd9;
        #1;
        check("fl_pre_we_c", {31'd0, wc[2]}, 32'd1);
        check("fl_pre_hit", {31'd0, hita[2]}, 32'd1);
        check("fl_pre_fwd_young", qda[2], 32'd6);
        en = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", {31'd0, v[2]}, 32'd0);
        check("fl_we_v", {31'd0, wv[2]}, 32'd0);
        check("fl_we_c", {31'd0, wc[2]}, 32'd0);
        check("fl_hit", {31'd0, hita[2]}, 32'd0);
        check("fl_qdata", qda[2], 32'd0);
        check("fl_payload_held", alu[2], 32'd4);

        // DEPTH=2 forwarding priority and data select.
        do_reset();
        en = 1'b1; valid_in = 1'b1; we_v_in = 1'b1; rg_in = 4'd5;
        sel_dat_in = 1'b1; do_in = 32'h22; alu_in = 32'h33; tick();
        sel_dat_in = 1'b0; do_in = 32'h44; alu_in = 32'h11; tick();
        en = 1'b0;
        q_rg_a = 4'd5; q_rg_b = 4'd6;
        #1;
        check("fw_hit_a", {31'd0, hita[1]}, 32'd1);
        check("fw_data_young", qda[1], 32'h11);
        check("fw_hit_b_miss", {31'd0, hitb[1]}, 32'd0);
        check("fw_data_b_miss", qdb[1], 32'd0);
        check("fw_out_do", dout[1], 32'h22);
        en = 1'b1;
        sel_dat_in = 1'b1; do_in = 32'h22; alu_in = 32'h33; tick();
        sel_dat_in = 1'b0; do_in = 32'h44; alu_in = 32'h11; we_v_in = 1'b0; tick();
        en = 1'b0;
        #1;
        check("fw_hit_old", {31'd0, hita[1]}, 32'd1);
        check("fw_data_old", qda[1], 32'h22);

        // Bubble gating of write enables.
        do_reset();
        en = 1'b1; valid_in = 1'b0; we_v_in = 1'b1; we_c_in = 1'b1;
        tick();
        check("bub_valid", {31'd0, v[0]}, 32'd0);
        check("bub_we_v", {31'd0, wv[0]}, 32'd0);
        check("bub_we_c", {31'd0, wc[0]}, 32'd0);

        // Asynchronous reset mid-cycle.
        valid_in = 1'b1; we_v_in = 1'b1; alu_in = 32'h5A; rg_in = 4'd2;
        tick();
        check("ar_pre_valid", {31'd0, v[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, v[0]}, 32'd0);
        check("ar_alu", alu[0], 32'd0);
        check("ar_rg", {28'd0, rg[0]}, 32'd0);
        check("ar_we_v", {31'd0, wv[0]}, 32'd0);
        clr_in();
        #1 rst_n = 1'b1;

`ifdef MEM_WB_BUBBLE_CNT_EN
        do_reset();
        check("bc_reset", {16'd0, bc[2]}, 32'd0);
        en = 1'b1; valid_in = 1'b0;
        tick(); tick(); tick();
        check("bc_three_d3", {16'd0, bc[2]}, 32'd3);
        check("bc_three_d1", {16'd0, bc[0]}, 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0; en = 1'b0;
        check("bc_flush_hold", {16'd0, bc[2]}, 32'd3);
        do_reset();
        check("bc_cleared", {16'd0, bc[2]}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised successor of the MEM/WB pipeline register: DEPTH-stage register chain carrying write-back payload and control from memory stage to write-back stage.
- Adds a valid bit per stage, stall (hold), flush (bubble insert), registered destination register, and a combinational forwarding lookup into all in-flight stages.
- Sits between data-memory/ALU outputs and the register-file write-back mux.

Parameters:
- DATA_W, 32, width of memory word (do) and ALU result.
- BYTE_W, 8, width of byte-memory read data (dob).
- RG_W, 4, destination register index width.
- DEPTH, 1, number of register stages (1..4); output taken from stage DEPTH-1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; 0 = stall (hold all stages).
- flush  in  1  synchronous bubble insert into all stages.
- valid_in  in  1  incoming slot carries a real instruction.
- sel_dat_in, sel_c_in, we_v_in, we_c_in, sel_sto_in  in  1 each  write-back control.
- do_in  in  DATA_W  memory word.
- dob_in  in  BYTE_W  byte-memory data.
- alu_result_in  in  DATA_W  ALU result.
- rg_in  in  RG_W  destination register.
- q_rg_a, q_rg_b  in  RG_W  forwarding query registers.
- valid  out  1  output stage valid.
- sel_dat, sel_c, we_v, we_c, sel_sto  out  1 each  output-stage control.
- do_out  out  DATA_W;  dob  out  BYTE_W;  alu_result  out  DATA_W;  rg  out  RG_W  output-stage payload.
- q_hit_a, q_hit_b  out  1  query matched an in-flight write.
- q_data_a, q_data_b  out  DATA_W  forwarded value.

Behaviour:
- Reset (rst_n=0, async): every stage valid, control, payload and rg cleared to 0; all outputs 0 immediately, independent of clk.
- Priority per rising edge: flush > stall > advance.
- flush=1: all stages valid=0, we_v=0, we_c=0, remaining control 0; payload/rg held. Applies even when en=0.
- flush=0, en=0: all stages hold exactly.
- flush=0, en=1: stage0 <= inputs (valid_in included); stage k <= stage k-1 for k=1..DEPTH-1.
- Bubble gating: on load, a stage with valid_in=0 stores we_v=0, we_c=0 regardless of we_v_in/we_c_in; outputs we_v/we_c therefore never assert while valid=0.
- Latency: DEPTH cycles from input to outputs with en held 1; each stall cycle adds one.
- rg is registered with the payload (no combinational pass-through).
- Forwarding (combinational, no clock): for query q, candidate stage k hits when valid_k=1, we_v_k=1, rg_k==q. Youngest stage (lowest k) wins. q_data = sel_dat_k ? do_k : alu_result_k of winning stage. No hit: q_hit=0, q_data=0. Query of register 0 behaves like any other index.
- Mid-operation reset clears in-flight instructions; first valid output after release requires DEPTH advancing edges.
- DEPTH outside 1..4: elaboration error.

Optional Feature:
- Macro MEM_WB_BUBBLE_CNT_EN.
- Defined: extra port bubble_cnt out 16; increments by 1 on each rising edge where en=1, flush=0 and output stage loads valid=0 from stage DEPTH-2 (or from valid_in when DEPTH=1); saturates at 16'hFFFF; cleared by reset only, not by flush.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- DEPTH=1, valid_in=1, we_v_in=1, alu_result_in=32'h0000_00A5, rg_in=3, en=1 -> after 1 edge valid=1, we_v=1, alu_result=32'hA5, rg=3; rg unchanged while rg_in toggles between edges.
- DEPTH=3, stream 3 valid words 1,2,3 -> outputs 1,2,3 appear on edges 3,4,5; en=0 for 2 cycles mid-stream -> outputs freeze, sequence intact, no duplicates or losses.
- flush=1 with en=0 and 3 valid stages -> next edge valid=0, we_v=0, we_c=0; q_hit_a=0 for any query.
- DEPTH=2, stage0 rg=5 sel_dat=0 alu=32'h11, stage1 rg=5 sel_dat=1 do=32'h22, q_rg_a=5 -> q_hit_a=1, q_data_a=32'h11; clear stage0 we_v -> q_data_a=32'h22.
- valid_in=0 with we_v_in=1 we_c_in=1 -> output we_v=0, we_c=0, valid=0.
- Assert rst_n=0 between edges with valid data -> all outputs 0 before next edge; with MEM_WB_BUBBLE_CNT_EN, 3 bubbles advanced through -> bubble_cnt=3, flush leaves it at 3, reset clears it to 0.
